// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if
// Groups the control inputs and status outputs of the down-counter timer.
//   load        : load request, captures load_val as the new start value
//   load_val    : start value (WIDTH bits)
//   en          : count enable, one decrement per cycle while high
//   auto_reload : restart from the stored start value after terminal count
//   q           : current count (registered)
//   tc          : one-cycle terminal-count pulse (registered)
//   busy        : high while counting or in the expired cycle (registered)
// master drives the controls; slave is the timer itself.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_val, en, auto_reload,
    input  q, tc, busy
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output q, tc, busy
  );
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer
// Synchronous programmable down-counter used as a period/timeout generator.
// Loads a start value, counts down to zero while enabled and raises tc for
// exactly one cycle when q reaches zero. With auto_reload set it restarts
// from the last loaded value after that cycle.
// Ports:
//   clk   : single rising-edge clock
//   reset : synchronous active-high reset, dominates every other input
//   bus   : down_counter_timer_if slave (load, load_val, en, auto_reload,
//           q, tc, busy)
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;
  logic             busy_reg, busy_next;

  // All outputs come straight from flops so there is no input-to-output
  // combinational path.
  assign bus.q    = q_reg;
  assign bus.tc   = tc_reg;
  assign bus.busy = busy_reg;

  // State and datapath registers; reset wins over load and enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q_reg      <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state      <= state_next;
      q_reg      <= q_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
      busy_reg   <= busy_next;
    end
  end

  // Next-state and next-output logic. load beats en in every state,
  // including EXPIRED where it also beats the automatic reload.
  always_comb begin
    state_next  = state;
    q_next      = q_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    busy_next   = busy_reg;

    if (bus.load) begin
      reload_next = bus.load_val;
      q_next      = bus.load_val;
      // A zero start value never enters RUN, so it can never produce tc.
      if (bus.load_val != '0) begin
        state_next = RUN;
        busy_next  = 1'b1;
      end else begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          busy_next = 1'b0;
        end
        RUN: begin
          busy_next = 1'b1;
          if (bus.en) begin
            // q is never zero in RUN; the <=1 test still keeps a stray
            // zero from wrapping to all-ones.
            if (q_reg > WIDTH'(1)) begin
              q_next = q_reg - WIDTH'(1);
            end else begin
              q_next     = '0;
              tc_next    = 1'b1;
              state_next = EXPIRED;
            end
          end
        end
        EXPIRED: begin
          // auto_reload only matters here, on the cycle after terminal count.
          if (bus.auto_reload) begin
            q_next     = reload_reg;
            state_next = RUN;
            busy_next  = 1'b1;
          end else begin
            q_next     = '0;
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end
        default: begin
          q_next     = '0;
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer
// Directed scenarios from the timer's intended behaviour plus a randomized
// run checked against a cycle-level behavioural model of the timer.
module tb_down_counter_timer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: count value, active flag, pulse flag, stored start.
  logic [W-1:0] m_q;
  logic [W-1:0] m_reload;
  logic         m_tc;
  logic         m_busy;

  down_counter_timer_if #(.WIDTH(W)) bus ();

  down_counter_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic l, input logic [W-1:0] lv,
                       input logic e, input logic ar);
    bus.load        = l;
    bus.load_val    = lv;
    bus.en          = e;
    bus.auto_reload = ar;
  endtask

  // Advance one clock, update the model from the inputs seen at that edge,
  // then settle 1 time unit past the edge for sampling.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_q = '0; m_reload = '0; m_tc = 1'b0; m_busy = 1'b0;
    end else if (bus.load) begin
      m_reload = bus.load_val;
      m_q      = bus.load_val;
      m_tc     = 1'b0;
      m_busy   = (bus.load_val != '0);
    end else if (m_tc) begin
      m_tc = 1'b0;
      if (bus.auto_reload) begin
        m_q    = m_reload;
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end else if (m_busy && bus.en) begin
      m_q = m_q - 1'b1;
      if (m_q == '0) m_tc = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, W'($urandom), 1'b1, 1'b1);
    step();
    checks++;
    if (bus.q !== '0 || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset: q=%0d tc=%b busy=%b, required q=0 tc=0 busy=0",
               bus.q, bus.tc, bus.busy);
    end
    reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_one_shot();
    logic [W-1:0] eq [8];
    logic         et [8];
    logic         eb [8];
    eq = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    drive(1'b1, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (bus.q !== eq[i] || bus.tc !== et[i] || bus.busy !== eb[i]) begin
        failures++;
        $display("[TB] FAIL one_shot[%0d]: q=%0d tc=%b busy=%b, required q=%0d tc=%b busy=%b",
                 i, bus.q, bus.tc, bus.busy, eq[i], et[i], eb[i]);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] eq [9];
    eq = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
    drive(1'b1, 4'd3, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      drive(1'b0, '0, 1'b1, 1'b1);
      checks++;
      if (bus.q !== eq[i] || bus.tc !== (eq[i] == 0) || bus.busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL auto_reload[%0d]: q=%0d tc=%b busy=%b, required q=%0d tc=%b busy=1",
                 i, bus.q, bus.tc, bus.busy, eq[i], (eq[i] == 0));
      end
    end
  endtask

  task automatic test_en_gating();
    logic [W-1:0] eq [6];
    logic         en_pat [6];
    eq     = '{4'd6, 4'd5, 4'd5, 4'd5, 4'd4, 4'd3};
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(1'b1, 4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      drive(1'b0, '0, en_pat[i], 1'b0);
      checks++;
      if (bus.q !== eq[i] || bus.tc !== 1'b0) begin
        failures++;
        $display("[TB] FAIL en_gating[%0d]: q=%0d tc=%b, required q=%0d tc=0",
                 i, bus.q, bus.tc, eq[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    logic [W-1:0] eq [10];
    eq = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd9, 4'd8, 4'd7, 4'd6};
    drive(1'b1, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      // Reload to 9 with en high on the edge after q reads 2.
      if (i == 5) drive(1'b1, 4'd9, 1'b1, 1'b0);
      else        drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (bus.q !== eq[i] || bus.tc !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL load_priority[%0d]: q=%0d tc=%b busy=%b, required q=%0d tc=0 busy=1",
                 i, bus.q, bus.tc, bus.busy, eq[i]);
      end
    end
  endtask

  task automatic test_zero_and_max();
    int tc_seen = 0;
    drive(1'b1, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 21; i++) begin
      step();
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (bus.q !== '0 || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL zero_load[%0d]: q=%0d tc=%b busy=%b, required q=0 tc=0 busy=0",
                 i, bus.q, bus.tc, bus.busy);
      end
    end
    drive(1'b1, 4'd15, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      step();
      drive(1'b0, '0, 1'b1, 1'b0);
      if (bus.tc === 1'b1) tc_seen++;
      checks++;
      if (bus.q !== ((i <= 15) ? W'(15 - i) : W'(0))) begin
        failures++;
        $display("[TB] FAIL max_count[%0d]: q=%0d, required q=%0d",
                 i, bus.q, (i <= 15) ? 15 - i : 0);
      end
    end
    checks++;
    if (tc_seen != 1) begin
      failures++;
      $display("[TB] FAIL max_tc_count: pulses=%0d, required 1", tc_seen);
    end
  endtask

  task automatic test_reset_midcount();
    drive(1'b1, 4'd8, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b0, '0, 1'b1, 1'b1);
    end
    checks++;
    if (bus.q !== 4'd4 || bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midcount_setup: q=%0d busy=%b, required q=4 busy=1", bus.q, bus.busy);
    end
    reset = 1'b1;
    drive(1'b1, 4'd11, 1'b1, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.q !== '0 || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_midcount[%0d]: q=%0d tc=%b busy=%b, required q=0 tc=0 busy=0",
                 i, bus.q, bus.tc, bus.busy);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(99) < 2);
      drive(($urandom_range(99) < 8), W'($urandom),
            ($urandom_range(99) < 75), $urandom_range(1));
      if ($urandom_range(99) < 4) bus.load_val = (i[0]) ? '0 : '1;
      step();
      checks++;
      if (bus.q !== m_q || bus.tc !== m_tc || bus.busy !== m_busy) begin
        failures++;
        $display("[TB] FAIL random[%0d]: q=%0d tc=%b busy=%b, required q=%0d tc=%b busy=%b",
                 i, bus.q, bus.tc, bus.busy, m_q, m_tc, m_busy);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m_q = '0; m_reload = '0; m_tc = 1'b0; m_busy = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_en_gating();
    test_load_priority();
    test_zero_and_max();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
